// File: rtl/svm_pkg.sv
// Shared constants and state type for the SVM coefficient loader.
// One RAM line holds a 15x7 block of Q4.12 coefficients.
package svm_pkg;

    localparam int FEA_I  = 4;
    localparam int FEA_F  = 12;
    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int COEF_W = FEA_W;
    localparam int ROW    = 15;
    localparam int COL    = 7;
    localparam int N_COEF = ROW * COL;
    localparam int RAM_DW = COEF_W * N_COEF;
    localparam int N_LINE = 36;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_BIAS  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } load_state_t;

endpackage

// File: rtl/svm_coef_packer.sv
// Line packer: shifts accepted coefficients in from the top so that beat 0
// ends up in the lowest slice once a full line has been collected.
// 'line' is the packed line including the beat currently being shifted in,
// so the caller can capture a complete line on the edge of the last beat.
module svm_coef_packer
    import svm_pkg::*;
#(
    parameter int W = COEF_W,
    parameter int N = N_COEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           shift_en,
    input  logic [W-1:0]   coef,
    output logic [W*N-1:0] line,
    output logic           last
);

    localparam int CNT_W = $clog2(N);

    // Only the upper N-1 slices need storage; the newest beat comes from coef.
    logic [W*(N-1)-1:0] pack_r;
    logic [CNT_W-1:0]   coef_cnt_r;

    assign line = {coef, pack_r};
    assign last = shift_en && (coef_cnt_r == CNT_W'(N - 1));

    // Pack register and beat counter; the counter wraps to 0 after the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_r     <= {(W*(N-1)){1'b0}};
            coef_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            coef_cnt_r <= {CNT_W{1'b0}};
        end else if (shift_en) begin
            pack_r     <= line[W*N-1:W];
            coef_cnt_r <= last ? {CNT_W{1'b0}} : coef_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/svm_coef_loader.sv
// Coefficient RAM / bias writer for the SVM classifier core.
// Collects 105 beats per RAM line, writes N_LINE lines, then loads the bias.
// Build option: define SVM_LOAD_CHECKSUM_EN to require a trailing checksum
// beat (wrap-around sum of all coefficient and bias beats); a mismatch
// raises err at the done pulse. Without it err is tied low.
module svm_coef_loader #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 12,
    parameter int N_LINE = 36,
    parameter int ADDR_W = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_valid,
    input  logic [FEA_I+FEA_F-1:0]          s_data,
    output logic                            s_ready,
    output logic [ADDR_W-1:0]               addr_a,
    output logic                            write_en,
    output logic [(FEA_I+FEA_F)*15*7-1:0]   i_data,
    output logic [FEA_I+FEA_F-1:0]          bias,
    output logic                            b_load,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    import svm_pkg::*;

    localparam int COEF_BITS = FEA_I + FEA_F;
    localparam int LINE_BITS = COEF_BITS * N_COEF;

    load_state_t          state_r;
    logic [ADDR_W-1:0]    line_cnt_r;
    logic                 accept_s;
    logic                 pack_clr_s;
    logic                 pack_shift_s;
    logic                 pack_last_s;
    logic [LINE_BITS-1:0] pack_line_s;

    assign accept_s     = s_valid && s_ready;
    assign pack_clr_s   = (state_r == ST_IDLE) && start;
    assign pack_shift_s = accept_s && (state_r == ST_FILL);

    svm_coef_packer #(
        .W (COEF_BITS),
        .N (N_COEF)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pack_clr_s),
        .shift_en (pack_shift_s),
        .coef     (s_data),
        .line     (pack_line_s),
        .last     (pack_last_s)
    );

    // Load sequencer with all host/RAM-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            line_cnt_r <= {ADDR_W{1'b0}};
            s_ready    <= 1'b0;
            addr_a     <= {ADDR_W{1'b0}};
            write_en   <= 1'b0;
            i_data     <= {LINE_BITS{1'b0}};
            bias       <= {COEF_BITS{1'b0}};
            b_load     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            write_en <= 1'b0;
            b_load   <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_FILL;
                        line_cnt_r <= {ADDR_W{1'b0}};
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_FILL: begin
                    // Capture the line on the edge of its last beat so the
                    // strobe lands exactly one cycle later.
                    if (pack_last_s) begin
                        state_r  <= ST_WRITE;
                        s_ready  <= 1'b0;
                        write_en <= 1'b1;
                        addr_a   <= line_cnt_r;
                        i_data   <= pack_line_s;
                    end
                end
                ST_WRITE: begin
                    s_ready <= 1'b1;
                    if (line_cnt_r == ADDR_W'(N_LINE - 1)) begin
                        state_r <= ST_BIAS;
                    end else begin
                        line_cnt_r <= line_cnt_r + ADDR_W'(1);
                        state_r    <= ST_FILL;
                    end
                end
                ST_BIAS: begin
                    if (accept_s) begin
                        bias   <= s_data;
                        b_load <= 1'b1;
`ifdef SVM_LOAD_CHECKSUM_EN
                        state_r <= ST_CHECK;
`else
                        state_r <= ST_DONE;
                        s_ready <= 1'b0;
`endif
                    end
                end
`ifdef SVM_LOAD_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept_s) begin
                        state_r <= ST_DONE;
                        s_ready <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SVM_LOAD_CHECKSUM_EN
    logic [COEF_BITS-1:0] sum_r;
    logic                 chk_bad_r;

    function automatic logic [COEF_BITS-1:0] csum_add(
        input logic [COEF_BITS-1:0] acc,
        input logic [COEF_BITS-1:0] beat
    );
        return acc + beat;
    endfunction

    // Running wrap-around sum of every coefficient and bias beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= {COEF_BITS{1'b0}};
        end else if (pack_clr_s) begin
            sum_r <= {COEF_BITS{1'b0}};
        end else if (accept_s && ((state_r == ST_FILL) || (state_r == ST_BIAS))) begin
            sum_r <= csum_add(sum_r, s_data);
        end else begin
            sum_r <= sum_r;
        end
    end

    // Compare the checksum beat, publish the verdict with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_bad_r <= 1'b0;
            err       <= 1'b0;
        end else if (pack_clr_s) begin
            chk_bad_r <= 1'b0;
            err       <= 1'b0;
        end else if (accept_s && (state_r == ST_CHECK)) begin
            chk_bad_r <= (s_data != sum_r);
        end else if (state_r == ST_DONE) begin
            err <= chk_bad_r;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_svm_coef_loader.sv
// Directed/randomized bench for svm_coef_loader with a line-level reference.
module tb_svm_coef_loader;

    localparam int CW = 16;
    localparam int NC = 105;
    localparam int NL = 36;
    localparam int AW = 6;
    localparam int DW = CW * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [CW-1:0] s_data;
    logic          s_ready;
    logic [AW-1:0] addr_a;
    logic          write_en;
    logic [DW-1:0] i_data;
    logic [CW-1:0] bias;
    logic          b_load;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    svm_coef_loader #(
        .FEA_I (4),
        .FEA_F (12),
        .N_LINE(NL),
        .ADDR_W(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .addr_a  (addr_a),
        .write_en(write_en),
        .i_data  (i_data),
        .bias    (bias),
        .b_load  (b_load),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference contents of one load: beat value per line/position, plus bias
    logic [CW-1:0] beat_v [NL][NC];
    logic [CW-1:0] bias_v;

    // monitor records
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [CW-1:0] bias_q    [$];
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   bload_cyc = 0;
    int   ready_bad = 0;
    logic err_at_done  = 1'b0;
    logic busy_at_done = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (write_en) begin
            wr_addr_q.push_back(addr_a);
            wr_data_q.push_back(i_data);
            if (s_ready) ready_bad <= ready_bad + 1;
        end
        if (b_load) begin
            bias_q.push_back(bias);
            bload_cyc <= cyc;
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            err_at_done  <= err;
            busy_at_done <= busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int first;
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            first = 0;
            for (int k = NC - 1; k >= 0; k--)
                if (obs[k*CW +: CW] !== exp[k*CW +: CW]) first = k;
            $error("FAIL %s: slice %0d observed %0h expected %0h", tag, first,
                   obs[first*CW +: CW], exp[first*CW +: CW]);
        end
    endtask

    // beat k of line L belongs in slice k of the RAM word
    function automatic logic [DW-1:0] exp_line(input int L);
        logic [DW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*CW +: CW] = beat_v[L][k];
        return r;
    endfunction

    task automatic fill_values(input bit rnd);
        for (int L = 0; L < NL; L++)
            for (int k = 0; k < NC; k++)
                beat_v[L][k] = rnd ? CW'($urandom) : CW'(L * NC + k);
        bias_v = rnd ? CW'($urandom) : 16'h1234;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_s_ready"},  32'(s_ready),  32'd0);
        chk({pfx, "_addr_a"},   32'(addr_a),   32'd0);
        chk({pfx, "_write_en"}, 32'(write_en), 32'd0);
        chk_line({pfx, "_i_data"}, i_data, {DW{1'b0}});
        chk({pfx, "_bias"},     32'(bias),     32'd0);
        chk({pfx, "_b_load"},   32'(b_load),   32'd0);
        chk({pfx, "_busy"},     32'(busy),     32'd0);
        chk({pfx, "_done"},     32'(done),     32'd0);
        chk({pfx, "_err"},      32'(err),      32'd0);
    endtask

    // present one beat and hold it until the loader takes it
    task automatic send_beat(input logic [CW-1:0] v, input bit gaps);
        int guard;
        if (gaps && ($urandom_range(1, 0) == 0)) begin
            s_valid = 1'b0;
            repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = v;
        guard   = 0;
        while (!s_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        n_vec++;
        assert (guard < 50) else begin
            n_err++;
            $error("FAIL beat_stall: s_ready low for %0d cycles, expected under 50", guard);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_load(input bit gaps, input int abort_line, input int abort_beat,
                            input bit glitch, input bit bad_sum);
        int            base_wr;
        int            base_done;
        int            guard;
        int            avail;
        logic [CW-1:0] sum;
        sum       = '0;
        base_wr   = wr_addr_q.size();
        base_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(s_ready), 32'd1);
        chk("err_cleared_by_start", 32'(err), 32'd0);
        for (int L = 0; L < NL; L++) begin
            for (int k = 0; k < NC; k++) begin
                if (L == abort_line && k == abort_beat) begin
                    s_valid = 1'b0;
                    rst     = 1'b1;
                    #1;
                    chk_quiet("abort");
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    return;
                end
                if (glitch && L == 5 && k == 50) start = 1'b1;
                send_beat(beat_v[L][k], gaps);
                start = 1'b0;
                sum   = sum + beat_v[L][k];
            end
            // strobe lands the cycle after beat 104; s_valid may stay high meanwhile
            chk("write_en_after_last", 32'(write_en), 32'd1);
            chk("addr_at_write", 32'(addr_a), 32'(L));
            chk("ready_low_in_write", 32'(s_ready), 32'd0);
        end
        send_beat(bias_v, gaps);
        sum = sum + bias_v;
`ifdef SVM_LOAD_CHECKSUM_EN
        send_beat(bad_sum ? sum + 16'd1 : sum, gaps);
`endif
        s_valid = 1'b0;
        guard   = 0;
        while (done_cnt == base_done && guard < 20) begin @(posedge clk); #1; guard++; end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt - base_done), 32'd1);
        chk("write_count", 32'(wr_addr_q.size() - base_wr), 32'(NL));
        avail = wr_addr_q.size() - base_wr;
        for (int i = 0; i < NL && i < avail; i++) begin
            chk("write_addr", 32'(wr_addr_q[base_wr + i]), 32'(i));
            chk_line("write_data", wr_data_q[base_wr + i], exp_line(i));
        end
        chk("bias_loaded", 32'(bias_q[bias_q.size() - 1]), 32'(bias_v));
        chk("bias_held", 32'(bias), 32'(bias_v));
        chk("done_after_bload", 32'(done_cyc > bload_cyc), 32'd1);
`ifdef SVM_LOAD_CHECKSUM_EN
        chk("err_at_done", 32'(err_at_done), 32'(bad_sum));
        chk("err_held", 32'(err), 32'(bad_sum));
`else
        chk("done_gap", 32'(done_cyc - bload_cyc), 32'd1);
        chk("err_at_done", 32'(err_at_done), 32'd0);
`endif
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ready_idle", 32'(s_ready), 32'd0);
        chk("ready_during_write", 32'(ready_bad), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_quiet("post_reset");

        // counting pattern, continuous valid
        fill_values(1'b0);
        run_load(1'b0, -1, 0, 1'b0, 1'b0);
        // same data with random valid gaps
        run_load(1'b1, -1, 0, 1'b0, 1'b0);
        // stray start in the middle of line 5
        run_load(1'b0, -1, 0, 1'b1, 1'b0);
        // reset after 50 beats of line 3, then a fresh load with new data
        fill_values(1'b1);
        run_load(1'b0, 3, 50, 1'b0, 1'b0);
        fill_values(1'b1);
        run_load(1'b0, -1, 0, 1'b0, 1'b0);
`ifdef SVM_LOAD_CHECKSUM_EN
        run_load(1'b0, -1, 0, 1'b0, 1'b1);
        run_load(1'b1, -1, 0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
